// File: rtl/rc_realigner_if.sv
// Requester-completion stream bundle: the IP-side RC AXI4-Stream input and the
// realigned user-side output, plus the protocol-error pulse.
interface rc_realigner_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 75
);
    localparam int KW = DATA_WIDTH / 32;

    logic [DATA_WIDTH-1:0]  s_axis_rc_tdata;
    logic                   s_axis_rc_tvalid;
    logic [TUSER_WIDTH-1:0] s_axis_rc_tuser;
    logic [KW-1:0]          s_axis_rc_tkeep;
    logic                   s_axis_rc_tlast;
    logic                   s_axis_rc_tready;

    logic                   m_valid;
    logic                   m_ready;
    logic [DATA_WIDTH-1:0]  m_data;
    logic [KW-1:0]          m_dw_keep;
    logic                   m_last;
    logic [95:0]            m_desc;
    logic                   m_err;
    logic                   proto_err;

    // Realigner side: consumes the RC stream, produces the payload stream.
    modport slave (
        input  s_axis_rc_tdata, s_axis_rc_tvalid, s_axis_rc_tuser,
        input  s_axis_rc_tkeep, s_axis_rc_tlast, m_ready,
        output s_axis_rc_tready, m_valid, m_data, m_dw_keep, m_last,
        output m_desc, m_err, proto_err
    );

    // Environment side: PCIe IP feeding completions, DMA logic draining payload.
    modport master (
        output s_axis_rc_tdata, s_axis_rc_tvalid, s_axis_rc_tuser,
        output s_axis_rc_tkeep, s_axis_rc_tlast, m_ready,
        input  s_axis_rc_tready, m_valid, m_data, m_dw_keep, m_last,
        input  m_desc, m_err, proto_err
    );
endinterface

// File: rtl/rc_realigner.sv
// Strips the 3-DW RC completion descriptor and shifts payload down by 96 bits so
// payload DW0 lands at bit 0; one output register stage with full backpressure.
//
// state  | meaning
// IDLE   | waiting for SOP; non-SOP beats are accepted and dropped
// ACTIVE | mid-packet; each beat emits {tdata[95:0], saved upper DWs}
// FLUSH  | last beat left N-3 DWs in the saver; emit them, input stalled
module rc_realigner #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 75,
    parameter int SOP_BIT     = 32
) (
    input logic              clk,
    input logic              rst,
    rc_realigner_if.slave    bus
);
    localparam int KW = DATA_WIDTH / 32;
    localparam int R  = KW - 3;
    localparam int SW = DATA_WIDTH - 96;
    localparam int CW = $clog2(KW + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          flush_cnt, flush_nxt;
    logic [SW-1:0]          sv;
    logic [95:0]            desc_q;

    logic                   ld, acc, sop, start;
    logic [CW-1:0]          n_dw;
    logic                   emit, e_last, cap, pe_nxt;
    logic [DATA_WIDTH-1:0]  e_data;
    logic [KW-1:0]          e_keep;
    logic [95:0]            e_desc;

    logic                   m_valid_q, m_last_q, m_err_q, proto_err_q;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic [KW-1:0]          m_keep_q;
    logic [95:0]            m_desc_q;

    function automatic logic [KW-1:0] dw_mask(input logic [CW-1:0] c);
        dw_mask = '0;
        for (int i = 0; i < KW; i++) dw_mask[i] = (i < int'(c));
    endfunction

    assign ld    = !m_valid_q || bus.m_ready;
    assign bus.s_axis_rc_tready = !rst && ld && (state != FLUSH);
    assign acc   = bus.s_axis_rc_tvalid && bus.s_axis_rc_tready;
    assign sop   = bus.s_axis_rc_tuser[SOP_BIT];
    // An SOP restarts capture from IDLE or ACTIVE alike; FLUSH never accepts.
    assign start = acc && sop;

    always_comb begin
        n_dw = '0;
        for (int i = 0; i < KW; i++) n_dw = n_dw + CW'(bus.s_axis_rc_tkeep[i]);
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        emit      = 1'b0;
        e_data    = '0;
        e_keep    = '0;
        e_last    = 1'b0;
        e_desc    = desc_q;
        cap       = 1'b0;
        pe_nxt    = 1'b0;
        if (start) begin
            cap    = 1'b1;
            pe_nxt = (state == ACTIVE);
            if (!bus.s_axis_rc_tlast) begin
                state_nxt = ACTIVE;
            end else if (n_dw > CW'(3)) begin
                state_nxt = FLUSH;
                flush_nxt = n_dw - CW'(3);
            end else begin
                // Descriptor-only completion: empty terminating beat.
                emit      = 1'b1;
                e_last    = 1'b1;
                e_desc    = bus.s_axis_rc_tdata[95:0];
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: ;
                ACTIVE: begin
                    if (acc) begin
                        emit   = 1'b1;
                        e_data = {bus.s_axis_rc_tdata[95:0], sv};
                        e_keep = '1;
                        if (bus.s_axis_rc_tlast) begin
                            if (n_dw > CW'(3)) begin
                                state_nxt = FLUSH;
                                flush_nxt = n_dw - CW'(3);
                            end else begin
                                e_keep    = dw_mask(CW'(R) + n_dw);
                                e_last    = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (ld) begin
                        emit      = 1'b1;
                        e_data    = {96'b0, sv};
                        e_keep    = dw_mask(flush_cnt);
                        e_last    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv          <= '0;
            desc_q      <= '0;
            proto_err_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_desc_q    <= '0;
            m_err_q     <= 1'b0;
        end else begin
            proto_err_q <= pe_nxt;
            if (acc) sv <= bus.s_axis_rc_tdata[DATA_WIDTH-1:96];
            if (cap) desc_q <= bus.s_axis_rc_tdata[95:0];
            // Data/keep/desc hold across idle loads; only valid and last drop.
            if (ld) begin
                m_valid_q <= emit;
                m_last_q  <= emit && e_last;
                if (emit) begin
                    m_data_q <= e_data;
                    m_keep_q <= e_keep;
                    m_desc_q <= e_desc;
                    m_err_q  <= (e_desc[15:12] != 4'd0);
                end
            end
        end
    end

    assign bus.m_valid   = m_valid_q;
    assign bus.m_last    = m_last_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_dw_keep = m_keep_q;
    assign bus.m_desc    = m_desc_q;
    assign bus.m_err     = m_err_q;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_rc_realigner.sv
// Bench for rc_realigner: directed packet table, backpressure/reset/protocol
// sequences, randomized traffic against a payload-stream reference model.
module tb_rc_realigner;
    localparam int DW  = 256;
    localparam int KW  = DW / 32;
    localparam int TUW = 75;
    localparam int SOP = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc_realigner_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TUW)) bus ();
    rc_realigner #(.DATA_WIDTH(DW), .TUSER_WIDTH(TUW), .SOP_BIT(SOP)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));

    rc_realigner_if #(.DATA_WIDTH(512), .TUSER_WIDTH(161)) bus512 ();
    rc_realigner #(.DATA_WIDTH(512), .TUSER_WIDTH(161), .SOP_BIT(SOP)) u_dut512 (
        .clk(clk), .rst(rst), .bus(bus512));

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [95:0]   desc;
        logic          err;
    } exp_t;

    typedef struct {
        int           nb;
        int           n;
        logic [3:0]   ec;
        int           exp_beats;
        logic [KW-1:0] exp_last_keep;
        logic         exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int rdy_mode, pe_cnt, obs_cnt;
    bit mon_en, gap_en;
    logic [KW-1:0] obs_last_keep;
    logic          obs_err;
    logic [DW-1:0] obs_last_data;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] pk_data[$];
    logic [KW-1:0] pk_keep[$];
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] kmask(input int c);
        logic [KW-1:0] m;
        m = '0;
        for (int i = 0; i < c && i < KW; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] dmask(input logic [KW-1:0] k);
        logic [DW-1:0] m;
        for (int i = 0; i < KW; i++) m[i*32 +: 32] = {32{k[i]}};
        return m;
    endfunction

    task automatic build_packet(input int nb, input int n, input logic [3:0] ec);
        logic [DW-1:0] d;
        pk_data.delete();
        pk_keep.delete();
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < KW; i++) d[i*32 +: 32] = $urandom;
            if (b == 0) d[15:12] = ec;
            pk_data.push_back(d);
            pk_keep.push_back((b == nb - 1) ? kmask(n) : {KW{1'b1}});
        end
    endtask

    // Payload = every valid DW of the packet minus the first three, cut into
    // KW-DW beats; a truncated packet only ever delivers its complete beats.
    task automatic model_packet(input bit trunc);
        logic [31:0] dws[$];
        logic [DW-1:0] d0;
        exp_t e;
        int p, nch, cnt;
        for (int b = 0; b < pk_data.size(); b++)
            for (int i = 0; i < KW; i++)
                if (pk_keep[b][i]) dws.push_back(pk_data[b][i*32 +: 32]);
        d0 = pk_data[0];
        p = dws.size() - 3;
        if (trunc) nch = p / KW;
        else nch = (p == 0) ? 1 : (p + KW - 1) / KW;
        for (int c = 0; c < nch; c++) begin
            e.data = '0;
            cnt = p - c * KW;
            if (cnt > KW) cnt = KW;
            for (int i = 0; i < cnt; i++) e.data[i*32 +: 32] = dws[3 + c*KW + i];
            e.keep = kmask(cnt);
            e.last = !trunc && (c == nch - 1);
            e.desc = d0[95:0];
            e.err  = (d0[15:12] != 4'd0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input bit sop, input bit last);
        logic [TUW-1:0] tu;
        bit acc;
        int t;
        tu = '0;
        tu[SOP] = sop;
        bus.s_axis_rc_tdata  = d;
        bus.s_axis_rc_tkeep  = k;
        bus.s_axis_rc_tuser  = tu;
        bus.s_axis_rc_tlast  = last;
        bus.s_axis_rc_tvalid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.s_axis_rc_tready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.s_axis_rc_tvalid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tready stuck low for %0d cycles, want 1", t);
        end
        if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic send_beats(input bit trunc);
        for (int b = 0; b < pk_data.size(); b++)
            send_beat(pk_data[b], pk_keep[b], b == 0, (b == pk_data.size() - 1) && !trunc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [DW-1:0] d, held;
        logic [511:0] b0, b1;
        logic [160:0] tu5;
        int t, nb, n;

        rst = 1'b1;
        mon_en = 1'b0; gap_en = 1'b0; rdy_mode = 0; pe_cnt = 0; obs_cnt = 0;
        bus.s_axis_rc_tdata = '0; bus.s_axis_rc_tvalid = 1'b0; bus.s_axis_rc_tuser = '0;
        bus.s_axis_rc_tkeep = '0; bus.s_axis_rc_tlast = 1'b0; bus.m_ready = 1'b1;
        bus512.s_axis_rc_tdata = '0; bus512.s_axis_rc_tvalid = 1'b0; bus512.s_axis_rc_tuser = '0;
        bus512.s_axis_rc_tkeep = '0; bus512.s_axis_rc_tlast = 1'b0; bus512.m_ready = 1'b1;

        //          nb  n  ec  beats last_keep err
        vecs[0] = '{1, 4, 4'd0, 1, 8'h01, 1'b0};
        vecs[1] = '{3, 3, 4'd0, 2, 8'hFF, 1'b0};
        vecs[2] = '{2, 8, 4'd0, 2, 8'h1F, 1'b0};
        vecs[3] = '{1, 3, 4'd4, 1, 8'h00, 1'b1};
        vecs[4] = '{2, 1, 4'd0, 1, 8'h3F, 1'b0};
        vecs[5] = '{1, 8, 4'd9, 1, 8'h1F, 1'b1};
        vecs[6] = '{2, 4, 4'd0, 2, 8'h01, 1'b0};
        vecs[7] = '{4, 2, 4'd0, 3, 8'h7F, 1'b0};

        fork
            forever begin
                @(posedge clk);
                #1;
                if (rdy_mode == 1) bus.m_ready = ($urandom_range(0, 3) != 0);
                else if (rdy_mode == 0) bus.m_ready = 1'b1;
            end
            forever begin
                @(negedge clk);
                if (!rst && bus.proto_err) pe_cnt++;
                if (!rst && mon_en && bus.m_valid && bus.m_ready) begin
                    obs_cnt++;
                    obs_last_keep = bus.m_dw_keep;
                    obs_err = bus.m_err;
                    obs_last_data = bus.m_data;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat got data %0h, want no beat", bus.m_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sb_keep", bus.m_dw_keep, mon_e.keep);
                        chk("sb_last", bus.m_last, mon_e.last);
                        chk("sb_data", bus.m_data & dmask(mon_e.keep), mon_e.data);
                        chk("sb_desc", bus.m_desc, mon_e.desc);
                        chk("sb_err", bus.m_err, mon_e.err);
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", bus.s_axis_rc_tready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_keep", bus.m_dw_keep, 0);
        chk("rst_m_desc", bus.m_desc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", bus.s_axis_rc_tready, 1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single beat SOP+last, tkeep=0x0F: one flush beat, one input stall
        build_packet(1, 4, 4'd0);
        d = pk_data[0];
        d[127:96] = 32'hA5A5A5A5;
        pk_data[0] = d;
        model_packet(1'b0);
        send_beats(1'b0);
        @(negedge clk);
        chk("c1_stall_tready", bus.s_axis_rc_tready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c1_tready", bus.s_axis_rc_tready, 1);
        chk("c1_valid", bus.m_valid, 1);
        chk("c1_dw0", bus.m_data[31:0], 32'hA5A5A5A5);
        chk("c1_keep", bus.m_dw_keep, 8'h01);
        chk("c1_last", bus.m_last, 1);
        @(posedge clk); #1;
        drain();

        // Directed packet table
        for (int v = 0; v < 8; v++) begin
            obs_cnt = 0;
            build_packet(vecs[v].nb, vecs[v].n, vecs[v].ec);
            model_packet(1'b0);
            send_beats(1'b0);
            drain();
            chk($sformatf("vec%0d_beats", v), obs_cnt, vecs[v].exp_beats);
            chk($sformatf("vec%0d_last_keep", v), obs_last_keep, vecs[v].exp_last_keep);
            chk($sformatf("vec%0d_err", v), obs_err, vecs[v].exp_err);
            if (vecs[v].exp_last_keep == '0)
                chk($sformatf("vec%0d_zero_data", v), obs_last_data, 0);
        end

        // Downstream stall for 3 cycles mid-packet
        rdy_mode = 2;
        bus.m_ready = 1'b1;
        build_packet(3, 8, 4'd0);
        model_packet(1'b0);
        fork
            send_beats(1'b0);
            begin
                t = 0;
                while (!bus.m_valid && t < 100) begin @(posedge clk); #1; t++; end
                chk("bp_valid_seen", bus.m_valid, 1);
                bus.m_ready = 1'b0;
                held = bus.m_data;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_tready", bus.s_axis_rc_tready, 0);
                    chk("bp_hold_data", bus.m_data, held);
                    chk("bp_hold_valid", bus.m_valid, 1);
                    @(posedge clk); #1;
                end
                bus.m_ready = 1'b1;
            end
        join
        drain();
        rdy_mode = 0;

        // Reset mid-packet, then a clean 3-beat packet
        mon_en = 1'b0;
        build_packet(3, 8, 4'd3);
        send_beat(pk_data[0], pk_keep[0], 1'b1, 1'b0);
        send_beat(pk_data[1], pk_keep[1], 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.m_valid, 0);
        chk("mid_rst_last", bus.m_last, 0);
        chk("mid_rst_data", bus.m_data, 0);
        chk("mid_rst_keep", bus.m_dw_keep, 0);
        chk("mid_rst_desc", bus.m_desc, 0);
        chk("mid_rst_err", bus.m_err, 0);
        chk("mid_rst_proto", bus.proto_err, 0);
        chk("mid_rst_tready", bus.s_axis_rc_tready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        obs_cnt = 0;
        build_packet(3, 3, 4'd0);
        model_packet(1'b0);
        send_beats(1'b0);
        drain();
        chk("post_rst_beats", obs_cnt, 2);

        // Second SOP while ACTIVE
        pe_cnt = 0;
        build_packet(2, KW, 4'd5);
        model_packet(1'b1);
        send_beats(1'b1);
        build_packet(3, 3, 4'd0);
        model_packet(1'b0);
        send_beats(1'b0);
        drain();
        chk("proto_err_pulses", pe_cnt, 1);

        // Randomized traffic with gaps and backpressure
        rdy_mode = 1;
        gap_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < KW; i++) d[i*32 +: 32] = $urandom;
                send_beat(d, {KW{1'b1}}, 1'b0, 1'($urandom_range(0, 1)));
            end
            nb = $urandom_range(1, 4);
            n = (nb == 1) ? $urandom_range(3, KW) : $urandom_range(1, KW);
            build_packet(nb, n, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
            model_packet(1'b0);
            send_beats(1'b0);
        end
        drain();
        rdy_mode = 0;
        gap_en = 1'b0;

        // 512-bit datapath: 2 beats, last tkeep all ones
        for (int i = 0; i < 16; i++) begin
            b0[i*32 +: 32] = $urandom;
            b1[i*32 +: 32] = $urandom;
        end
        tu5 = '0;
        tu5[SOP] = 1'b1;
        @(posedge clk); #1;
        bus512.s_axis_rc_tdata = b0; bus512.s_axis_rc_tkeep = 16'hFFFF;
        bus512.s_axis_rc_tuser = tu5; bus512.s_axis_rc_tlast = 1'b0; bus512.s_axis_rc_tvalid = 1'b1;
        @(negedge clk);
        chk("w512_tready0", bus512.s_axis_rc_tready, 1);
        @(posedge clk); #1;
        bus512.s_axis_rc_tdata = b1; bus512.s_axis_rc_tuser = '0; bus512.s_axis_rc_tlast = 1'b1;
        @(negedge clk);
        chk("w512_tready1", bus512.s_axis_rc_tready, 1);
        @(posedge clk); #1;
        bus512.s_axis_rc_tvalid = 1'b0;
        @(negedge clk);
        chk("w512_o0_valid", bus512.m_valid, 1);
        chk("w512_o0_keep", bus512.m_dw_keep, 16'hFFFF);
        chk("w512_o0_last", bus512.m_last, 0);
        chk("w512_o0_dw0", bus512.m_data[31:0], b0[127:96]);
        chk("w512_o0_top", bus512.m_data[511:416], b1[95:0]);
        chk("w512_flush_tready", bus512.s_axis_rc_tready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w512_o1_valid", bus512.m_valid, 1);
        chk("w512_o1_keep", bus512.m_dw_keep, 16'h1FFF);
        chk("w512_o1_last", bus512.m_last, 1);
        chk("w512_o1_dw0", bus512.m_data[31:0], b1[127:96]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w512_idle_valid", bus512.m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
